// File: rtl/spi_ram_host_pkg.sv
// Shared definitions for the SPI RAM host: frame command codes, the sequencer
// state encoding and the helper that picks a frame's command.
package spi_ram_host_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_FRAME,
    ST_GAP,
    ST_DATA_FRAME,
    ST_RD_WAIT,
    ST_CAPTURE
  } state_t;

  function automatic logic [1:0] frame_cmd(input logic write, input logic data_frame);
    if (write) return data_frame ? CMD_WR_DATA : CMD_WR_ADDR;
    else       return data_frame ? CMD_RD_DATA : CMD_RD_ADDR;
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Serializes one {cmd[1], cmd, payload} frame onto MOSI behind a leading zero
// bit and deserializes the MISO data byte MSB first.
module spi_frame_shifter #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ADDR_SIZE+2:0] word,
  input  logic                 capture,
  input  logic                 miso,
  output logic                 mosi,
  output logic [ADDR_SIZE-1:0] rx_data
);

  localparam int WORD_W = ADDR_SIZE + 3;

  // One extra bit so frame cycle 0 drives 0; zeros refill behind the frame,
  // which keeps MOSI low through the read wait, capture and gaps.
  logic [WORD_W:0] tx;

  assign mosi = tx[WORD_W];

  // NOTE: non-blocking assignments for all registers, so every update in a
  // clock edge sees the values from before that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= '0;
      rx_data <= '0;
    end else begin
      if (load) tx <= {1'b0, word};
      else      tx <= {tx[WORD_W-1:0], 1'b0};
      if (capture) rx_data <= {rx_data[ADDR_SIZE-2:0], miso};
    end
  end

endmodule

// File: rtl/spi_ram_host.sv
// SPI RAM host: accepts one read/write request at a time, sequences the
// address and data frames (skipping cached addresses) and reports completion.
// IDLE_GAP and ADDR_SIZE must be at least 1 and 2 respectively.
module spi_ram_host
  import spi_ram_host_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int IDLE_GAP  = 2,
  parameter int RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int FRAME_LEN = ADDR_SIZE + 4;
  localparam int WORD_W    = ADDR_SIZE + 3;
  localparam int CNT_W     = $clog2(FRAME_LEN + RD_LAT + ADDR_SIZE + IDLE_GAP + 1);

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic                 last;
  logic                 accept;
  logic                 addr_hit;
  logic                 lat_write, data_phase;
  logic [ADDR_SIZE-1:0] lat_addr, lat_wdata;
  logic                 wr_cache_valid, rd_cache_valid;
  logic [ADDR_SIZE-1:0] wr_cache, rd_cache;
  logic                 cur_write;
  logic [ADDR_SIZE-1:0] cur_addr, cur_wdata, payload;
  logic [1:0]           cmd;
  logic                 load;
  logic [WORD_W-1:0]    word;
  logic [ADDR_SIZE-1:0] rx_data;

  assign accept   = req_valid && req_ready;
  assign addr_hit = req_write ? (wr_cache_valid && wr_cache == req_addr)
                              : (rd_cache_valid && rd_cache == req_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state || state == ST_IDLE) ? '0 : cnt + CNT_W'(1);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    last = 1'b0;
    unique case (state)
      ST_ADDR_FRAME, ST_DATA_FRAME: last = (cnt == CNT_W'(FRAME_LEN - 1));
      ST_GAP:                       last = (cnt == CNT_W'(IDLE_GAP - 1));
      ST_RD_WAIT:                   last = (cnt == CNT_W'(RD_LAT - 1));
      ST_CAPTURE:                   last = (cnt == CNT_W'(ADDR_SIZE - 1));
      default:                      last = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:       if (accept) state_next = addr_hit ? ST_DATA_FRAME : ST_ADDR_FRAME;
      ST_ADDR_FRAME: if (last) state_next = ST_GAP;
      ST_GAP:        if (last) state_next = data_phase ? ST_IDLE : ST_DATA_FRAME;
      ST_DATA_FRAME: if (last) state_next = lat_write ? ST_GAP
                                          : (RD_LAT == 0 ? ST_CAPTURE : ST_RD_WAIT);
      ST_RD_WAIT:    if (last) state_next = ST_CAPTURE;
      ST_CAPTURE:    if (last) state_next = ST_GAP;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    SS_n      = !(state inside {ST_ADDR_FRAME, ST_DATA_FRAME, ST_RD_WAIT, ST_CAPTURE});
  end

  // The first frame is loaded on the acceptance edge, before the request is latched.
  always_comb begin
    cur_write = (state == ST_IDLE) ? req_write : lat_write;
    cur_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
    cur_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
    cmd       = frame_cmd(cur_write, state_next == ST_DATA_FRAME);
    payload   = (state_next == ST_ADDR_FRAME) ? cur_addr : (cur_write ? cur_wdata : '0);
    word      = {cmd[1], cmd, payload};
    load      = (state_next != state) && (state_next inside {ST_ADDR_FRAME, ST_DATA_FRAME});
  end

  // NOTE: request and cache values are plain data registers left out of reset;
  // they are only ever consumed behind the state machine or a cleared valid flag.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
    if (state == ST_ADDR_FRAME && last) begin
      if (lat_write) wr_cache <= lat_addr;
      else           rd_cache <= lat_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cache_valid <= 1'b0;
      rd_cache_valid <= 1'b0;
      data_phase     <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
    end else begin
      rsp_valid <= (state == ST_GAP) && last && data_phase;
      if (accept) data_phase <= 1'b0;
      if (load && state_next == ST_DATA_FRAME) data_phase <= 1'b1;
      if (state == ST_ADDR_FRAME && last) begin
        if (lat_write) wr_cache_valid <= 1'b1;
        else           rd_cache_valid <= 1'b1;
      end
      if (state == ST_GAP && last && data_phase && !lat_write) rsp_rdata <= rx_data;
    end
  end

  spi_frame_shifter #(.ADDR_SIZE(ADDR_SIZE)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .word    (word),
    .capture (state == ST_CAPTURE),
    .miso    (MISO),
    .mosi    (MOSI),
    .rx_data (rx_data)
  );

endmodule

// File: tb/tb_spi_ram_host.sv
// Bench for spi_ram_host: a behavioural SPI RAM slave on the bus, a request
// model that predicts frames, response data and completion cycle, and a monitor.
module tb_spi_ram_host;

  localparam int AW        = 8;
  localparam int IDLE_GAP  = 2;
  localparam int RD_LAT    = 2;
  localparam int SHORT_LEN = 12;                     // lead 0 + cmd[1] + cmd + 8 payload bits
  localparam int READ_LEN  = SHORT_LEN + RD_LAT + AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0, req_wdata = '0;
  logic          req_ready, rsp_valid, busy, SS_n, MOSI;
  logic [AW-1:0] rsp_rdata;
  logic          miso = 1'b0;

  always #5 clk = ~clk;

  spi_ram_host #(.ADDR_SIZE(AW), .IDLE_GAP(IDLE_GAP), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(miso)
  );

  typedef struct { logic write; logic [7:0] rdata; int due; } txn_t;
  typedef struct { logic [1:0] cmd; logic [7:0] payload; } frame_t;

  txn_t   sb_q[$];
  frame_t frame_q[$];
  int     checks = 0, errors = 0, cyc = 0, rsp_count = 0, prev_due = 0;
  logic [7:0] m_ram [256];
  logic       m_wr_valid = 1'b0, m_rd_valid = 1'b0;
  logic [7:0] m_wr_addr = '0, m_rd_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural SPI slave with RAM ----------------
  logic [7:0]  s_ram [256];
  bit          s_init = 0, s_in_frame = 0, s_rd_frame = 0, s_have_prev = 0, s_last_addr = 0;
  int          s_fcnt = 0, s_gap = 0;
  logic [11:0] s_bits = '0;
  logic [7:0]  s_waddr = '0, s_raddr = '0;

  always @(negedge clk) begin : slave
    frame_t     exp_f;
    logic [1:0] cmd;
    logic [7:0] pl;
    if (rst) begin
      if (!s_init) begin
        for (int i = 0; i < 256; i++) s_ram[i] = 8'($urandom);
        s_init = 1;
      end
      s_in_frame = 0; s_rd_frame = 0; s_have_prev = 0; s_gap = 0; miso = 1'b0;
    end else if (!SS_n) begin
      if (!s_in_frame) begin
        if (s_have_prev) begin
          if (s_last_addr) check("addr_data_gap", s_gap, IDLE_GAP);
          else             check("frame_gap_min", 32'(s_gap >= IDLE_GAP), 1);
        end
        s_in_frame = 1; s_fcnt = 0; s_rd_frame = 0;
      end else begin
        s_fcnt++;
      end
      if (s_fcnt == 0) check("mosi_lead_zero", MOSI, 0);
      if (s_fcnt < SHORT_LEN) s_bits[s_fcnt] = MOSI;
      else                    check("mosi_low_after_bits", MOSI, 0);
      if (s_fcnt == SHORT_LEN - 1) begin
        cmd = {s_bits[2], s_bits[3]};
        for (int i = 0; i < 8; i++) pl[7-i] = s_bits[4+i];
        check("cmd_msb_repeat", s_bits[1], cmd[1]);
        if (frame_q.size() == 0) check("frame_unexpected", 0, 1);
        else begin
          exp_f = frame_q.pop_front();
          check("frame_cmd", cmd, exp_f.cmd);
          check("frame_payload", pl, exp_f.payload);
        end
        case (cmd)
          2'b00: s_waddr = pl;
          2'b01: s_ram[s_waddr] = pl;
          2'b10: s_raddr = pl;
          default: s_rd_frame = 1;
        endcase
        s_last_addr = !cmd[0];
      end
      miso = 1'b0;
      if (s_rd_frame && s_fcnt >= SHORT_LEN + RD_LAT && s_fcnt < READ_LEN)
        miso = s_ram[s_raddr][READ_LEN-1-s_fcnt];
    end else begin
      if (s_in_frame) begin
        check("frame_len", s_fcnt + 1, s_rd_frame ? READ_LEN : SHORT_LEN);
        s_in_frame = 0; s_have_prev = 1; s_gap = 0;
      end
      s_gap++;
      check("mosi_low_ss_high", MOSI, 0);
      miso = 1'b0;
    end
  end

  // ---------------- response monitor ----------------
  logic [7:0] last_rd = '0;

  always @(negedge clk) begin : monitor
    txn_t t;
    if (rst) last_rd = '0;
    else if (rsp_valid) begin
      rsp_count++;
      check("ready_on_rsp", req_ready, 1);
      if (sb_q.size() == 0) check("rsp_unexpected", 0, 1);
      else begin
        t = sb_q.pop_front();
        check("rsp_cycle", cyc, t.due);
        check("rsp_rdata", rsp_rdata, t.write ? last_rd : t.rdata);
        if (!t.write) last_rd = t.rdata;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic write, input logic [7:0] addr, input logic [7:0] data,
                      input bit hold, input bit b2b);
    int     waited, lat;
    bit     hit;
    frame_t f;
    txn_t   t;
    req_valid = 1'b1; req_write = write; req_addr = addr; req_wdata = data;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!req_ready && waited < 200);
    if (!req_ready) begin
      check("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    check("busy_not_ready", busy, 0);
    if (b2b) check("b2b_accept_on_rsp", cyc, prev_due);
    hit = write ? (m_wr_valid && m_wr_addr == addr) : (m_rd_valid && m_rd_addr == addr);
    lat = 1;
    if (!hit) begin
      f.cmd = write ? 2'b00 : 2'b10; f.payload = addr;
      frame_q.push_back(f);
      lat += SHORT_LEN + IDLE_GAP;
    end
    f.cmd = write ? 2'b01 : 2'b11; f.payload = write ? data : 8'h00;
    frame_q.push_back(f);
    lat += (write ? SHORT_LEN : READ_LEN) + IDLE_GAP;
    if (write) begin m_wr_valid = 1'b1; m_wr_addr = addr; m_ram[addr] = data; end
    else       begin m_rd_valid = 1'b1; m_rd_addr = addr; end
    t.write = write; t.rdata = write ? 8'h00 : m_ram[addr]; t.due = cyc + lat;
    sb_q.push_back(t);
    prev_due = t.due;
    @(posedge clk); #1;
    // Scramble the request bus after acceptance; the transaction must not notice.
    req_addr = 8'($urandom); req_wdata = 8'($urandom); req_write = 1'($urandom);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check("drain", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int rc;
    int n;
    bit hold, prev_hold;
    repeat (3) @(negedge clk);
    check("rst_ss_n", SS_n, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    for (int i = 0; i < 256; i++) m_ram[i] = s_ram[i];
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    send(1, 8'h7F, 8'hA5, 0, 0);   // uncached write: A+29
    send(0, 8'h7F, 8'h00, 0, 0);   // uncached read:  A+39, data A5
    send(0, 8'h7F, 8'h00, 0, 0);   // cached read:    A+25
    send(1, 8'h10, 8'h3C, 0, 0);
    send(1, 8'h11, 8'hC3, 0, 0);
    send(0, 8'h10, 8'h00, 0, 0);   // returns 3C
    wait_idle();

    // Abort a read at frame cycle 6.
    send(0, 8'h7F, 8'h00, 0, 0);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!(s_in_frame && s_fcnt == 6) && n < 100);
    check("reached_frame_cycle_6", s_fcnt, 6);
    rst = 1'b1;
    sb_q.delete(); frame_q.delete();
    m_wr_valid = 1'b0; m_rd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ss_n_after_abort", SS_n, 1);
    check("mosi_after_abort", MOSI, 0);
    #1 rst = 1'b0;
    rc = rsp_count;
    repeat (45) @(negedge clk);
    check("no_rsp_after_abort", rsp_count, rc);
    @(posedge clk); #1;
    send(0, 8'h7F, 8'h00, 0, 0);   // caches cleared: address frame again
    wait_idle();

    // Back-to-back with req_valid held high.
    send(1, 8'h22, 8'h5A, 1, 0);
    send(0, 8'h22, 8'h00, 1, 1);
    send(0, 8'h22, 8'h00, 1, 1);
    send(1, 8'h22, 8'h96, 0, 1);
    wait_idle();

    // Randomized traffic over a small address pool to mix cache hits and misses.
    prev_hold = 0;
    for (int k = 0; k < 60; k++) begin
      hold = (k == 59) ? 1'b0 : 1'($urandom_range(0, 1));
      send(1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 3)), 8'($urandom), hold, prev_hold);
      prev_hold = hold;
      if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    check("frames_drained", frame_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
